fifo_wr_ingress: RTL and testbench

//  Write-domain front end of the async FIFO. Sits directly upstream of the write-pointer/full block.
//  - Accepts a valid/ready source stream into a 2-entry skid buffer.
//  - Drives wr_inc/wr_data into the FIFO write port.
//  - Synchronises the read-domain Gray pointer into wr_clk (r2w_ptr) and derives occupancy and almost-full.

---
 rtl/fifo_wr_ingress_if.sv | 31 +++
 rtl/fifo_wr_ingress.sv | 138 +++++++++++++
 tb/tb_fifo_wr_ingress.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_ingress_if.sv
// Write-domain ingress bundle: source valid/ready stream, FIFO write port,
// pointer exchange with the write-pointer/full block and status outputs.
interface fifo_wr_ingress_if #(
    parameter int ASIZE = 4,
    parameter int DSIZE = 8
);
    logic             s_valid;
    logic [DSIZE-1:0] s_data;
    logic             s_ready;
    logic [ASIZE:0]   rptr_gray_async;
    logic [ASIZE:0]   r2w_ptr;
    logic [ASIZE:0]   wr_ptr;
    logic             wr_full;
    logic             wr_inc;
    logic [DSIZE-1:0] wr_data;
    logic [ASIZE:0]   wr_count;
    logic             wr_almost_full;
    logic             proto_err;

    // Ingress block side.
    modport slave (
        input  s_valid, s_data, rptr_gray_async, wr_ptr, wr_full,
        output s_ready, r2w_ptr, wr_inc, wr_data, wr_count, wr_almost_full, proto_err
    );

    // Surrounding write-domain logic side (source, pointer/full block, memory).
    modport master (
        output s_valid, s_data, rptr_gray_async, wr_ptr, wr_full,
        input  s_ready, r2w_ptr, wr_inc, wr_data, wr_count, wr_almost_full, proto_err
    );
endinterface

// File: rtl/fifo_wr_ingress.sv
// Async FIFO write-domain front end: 2-entry skid buffer feeding the write port,
// read-pointer synchroniser, occupancy / almost-full and a sticky protocol check.
module fifo_wr_ingress #(
    parameter int ASIZE        = 4,
    parameter int DSIZE        = 8,
    parameter int AFULL_THRESH = 12
) (
    input  logic               wr_clk,
    input  logic               wr_rst,
    fifo_wr_ingress_if.slave   bus
);
    localparam logic [ASIZE:0] AFULL_LVL = (ASIZE+1)'(AFULL_THRESH);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    skid_state_e      state, next_state;
    logic [DSIZE-1:0] head, skid;
    logic             s_ready_q;
    logic             accept, drain;
    logic             head_load, head_from_skid, skid_load;
    logic [ASIZE:0]   sync1, r2w_q;
    logic [ASIZE:0]   wbin, rbin, count_next, count_q;
    logic             afull_q;
    logic             stall_q, proto_q;

    function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b[ASIZE] = g[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    assign accept = bus.s_valid & s_ready_q;
    assign drain  = (state != EMPTY) & ~bus.wr_full;

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        next_state     = state;
        head_load      = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    next_state = ONE;
                    head_load  = 1'b1;
                end
            end
            ONE: begin
                if (accept && !drain) begin
                    next_state = TWO;
                    skid_load  = 1'b1;
                end else if (accept && drain) begin
                    head_load = 1'b1;
                end else if (drain) begin
                    next_state = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    next_state     = ONE;
                    head_load      = 1'b1;
                    head_from_skid = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // pre-edge values regardless of the order in which processes are evaluated.
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state     <= EMPTY;
            s_ready_q <= 1'b0;
            head      <= '0;
        end else begin
            state     <= next_state;
            s_ready_q <= (next_state != TWO);
            if (head_load) head <= head_from_skid ? skid : bus.s_data;
        end
    end

    // NOTE: the skid word is pure storage qualified by the state register, so it
    // carries no reset; a stale value is never observable once state is EMPTY.
    always_ff @(posedge wr_clk) begin
        if (skid_load) skid <= bus.s_data;
    end

    // Plain two-flop synchroniser: Gray coding guarantees at most one bit in flight.
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            sync1 <= '0;
            r2w_q <= '0;
        end else begin
            sync1 <= bus.rptr_gray_async;
            r2w_q <= sync1;
        end
    end

    assign wbin       = gray2bin(bus.wr_ptr);
    assign rbin       = gray2bin(r2w_q);
    assign count_next = wbin - rbin;

    // Read pointer lags through the synchroniser, so the count can only over-report.
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            count_q <= '0;
            afull_q <= 1'b0;
        end else begin
            count_q <= count_next;
            afull_q <= (count_next >= AFULL_LVL);
        end
    end

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            stall_q <= 1'b0;
            proto_q <= 1'b0;
        end else begin
            stall_q <= bus.s_valid & ~s_ready_q;
            if (stall_q && !bus.s_valid) proto_q <= 1'b1;
        end
    end

    assign bus.s_ready        = s_ready_q;
    assign bus.r2w_ptr        = r2w_q;
    assign bus.wr_inc         = drain;
    assign bus.wr_data        = head;
    assign bus.wr_count       = count_q;
    assign bus.wr_almost_full = afull_q;
    assign bus.proto_err      = proto_q;
endmodule

// File: tb/tb_fifo_wr_ingress.sv
// Directed bench for fifo_wr_ingress: models the write-pointer/full block and the
// FIFO memory as a write log, and checks ordering, latency, sync, occupancy and reset.
module tb_fifo_wr_ingress;
    localparam int ASIZE = 4;
    localparam int DSIZE = 8;

    logic wr_clk = 1'b0;
    logic wr_rst;
    always #5 wr_clk = ~wr_clk;

    fifo_wr_ingress_if #(.ASIZE(ASIZE), .DSIZE(DSIZE)) bus ();

    fifo_wr_ingress #(.ASIZE(ASIZE), .DSIZE(DSIZE), .AFULL_THRESH(12)) dut (
        .wr_clk (wr_clk),
        .wr_rst (wr_rst),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DSIZE-1:0] wr_log[$];
    int               log_cyc[$];
    logic [ASIZE:0]   wbin, rptr_man;
    logic             full_reg, full_force, full_pat, use_auto, toggle_on, reader_on;
    logic [2:0]       ph;
    logic [7:0]       pat = 8'b1011_0110;
    int               rd_cnt;
    logic             mon_on, seen11, seen12, af_at11, af_at12;

    function automatic logic [ASIZE:0] b2g(input logic [ASIZE:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ASIZE:0] g2b(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b[ASIZE] = g[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    always @(posedge wr_clk) cyc <= cyc + 1;

    // Write-pointer/full block model and FIFO write log.
    always @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            wbin     <= '0;
            full_reg <= 1'b0;
        end else begin
            if (bus.wr_inc) wbin <= wbin + 5'd1;
            full_reg <= (5'(wbin + 5'(bus.wr_inc)) - g2b(bus.r2w_ptr)) == 5'd16;
        end
    end

    always @(posedge wr_clk) begin
        if (bus.wr_inc) begin
            wr_log.push_back(bus.wr_data);
            log_cyc.push_back(cyc);
        end
    end

    always @(negedge wr_clk) begin
        if (toggle_on) begin
            full_pat <= pat[ph];
            ph       <= ph + 3'd1;
        end else begin
            full_pat <= 1'b0;
            ph       <= '0;
        end
    end

    always @(negedge wr_clk) begin
        if (!reader_on) rd_cnt <= 0;
        else if (rd_cnt < 30 && rd_cnt < wr_log.size()) rd_cnt <= rd_cnt + 1;
    end

    always @(negedge wr_clk) begin
        if (mon_on) begin
            if (bus.wr_count == 5'd11 && !seen11) begin
                seen11 <= 1'b1; af_at11 <= bus.wr_almost_full;
            end
            if (bus.wr_count == 5'd12 && !seen12) begin
                seen12 <= 1'b1; af_at12 <= bus.wr_almost_full;
            end
        end else begin
            seen11 <= 1'b0; seen12 <= 1'b0; af_at11 <= 1'b0; af_at12 <= 1'b0;
        end
    end

    assign bus.wr_ptr          = b2g(wbin);
    assign bus.wr_full         = use_auto ? full_reg : (toggle_on ? full_pat : full_force);
    assign bus.rptr_gray_async = reader_on ? b2g(5'(rd_cnt)) : rptr_man;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_log(input string tag, input logic [7:0] base, input int n);
        check({tag, "_count"}, 32'(wr_log.size()), 32'(n));
        for (int i = 0; i < n && i < wr_log.size(); i++)
            check($sformatf("%s_w%0d", tag, i), 32'(wr_log[i]), 32'(8'(base + 8'(i))));
    endtask

    task automatic do_reset();
        @(negedge wr_clk);
        bus.s_valid = 1'b0;
        wr_rst      = 1'b1;
        @(negedge wr_clk);
        wr_rst = 1'b0;
        wr_log.delete();
        log_cyc.delete();
    endtask

    // Continuous source: holds each word until accepted, bounded by a cycle budget.
    task automatic send_words(input logic [7:0] base, input int n, input int budget,
                              input bit drop_at_end, output int sent,
                              output int first_cyc, output int gaps);
        int c = 0;
        sent = 0; first_cyc = -1; gaps = 0;
        while (sent < n && c < budget) begin
            @(negedge wr_clk);
            bus.s_valid = 1'b1;
            bus.s_data  = 8'(base + 8'(sent));
            @(posedge wr_clk);
            if (bus.s_ready) begin
                if (sent == 0) first_cyc = cyc;
                sent++;
            end else if (sent > 0) begin
                gaps++;
            end
            c++;
        end
        if (drop_at_end) begin
            @(negedge wr_clk);
            bus.s_valid = 1'b0;
        end
    endtask

    initial begin
        int sent, fc, gaps;
        wr_rst = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0; rptr_man = '0;
        use_auto = 1'b0; full_force = 1'b0; toggle_on = 1'b0; reader_on = 1'b0;
        mon_on = 1'b0;
        #1 wr_rst = 1'b1;
        #3;
        check("rst_s_ready",  32'(bus.s_ready), 0);
        check("rst_wr_inc",   32'(bus.wr_inc), 0);
        check("rst_wr_count", 32'(bus.wr_count), 0);
        check("rst_r2w_ptr",  32'(bus.r2w_ptr), 0);
        check("rst_afull",    32'(bus.wr_almost_full), 0);
        check("rst_proto",    32'(bus.proto_err), 0);
        @(negedge wr_clk);
        wr_rst = 1'b0;

        // 1: continuous stream, no backpressure.
        send_words(8'h00, 16, 40, 1'b1, sent, fc, gaps);
        check("t1_sent", 32'(sent), 16);
        check("t1_ready_gaps", 32'(gaps), 0);
        for (int i = 0; i < 10 && wr_log.size() < 16; i++) @(negedge wr_clk);
        check_log("t1", 8'h00, 16);
        check("t1_lat_first", 32'(log_cyc[0]), 32'(fc + 1));
        check("t1_lat_last", 32'(log_cyc[15]), 32'(fc + 16));
        repeat (2) @(negedge wr_clk);
        check("t1_count", 32'(bus.wr_count), 16);

        // 4: synchroniser latency at two different input phases.
        do_reset();
        @(posedge wr_clk); #3 rptr_man = 5'd1;
        @(posedge wr_clk); #1 check("t4_edge1", 32'(bus.r2w_ptr), 0);
        @(posedge wr_clk); #1 check("t4_edge2", 32'(bus.r2w_ptr), 1);
        #6 rptr_man = 5'd3;
        @(posedge wr_clk); #1 check("t4b_edge1", 32'(bus.r2w_ptr), 1);
        @(posedge wr_clk); #1 check("t4b_edge2", 32'(bus.r2w_ptr), 3);
        rptr_man = '0;

        // 2: reader frozen, FIFO fills to 16, two words stay buffered.
        do_reset();
        use_auto = 1'b1;
        mon_on   = 1'b1;
        send_words(8'h40, 20, 30, 1'b0, sent, fc, gaps);
        check("t2_accepted", 32'(sent), 18);
        check_log("t2", 8'h40, 16);
        check("t2_count", 32'(bus.wr_count), 16);
        check("t2_afull", 32'(bus.wr_almost_full), 1);
        check("t2_s_ready", 32'(bus.s_ready), 0);
        check("t2_seen12", 32'(seen12), 1);
        check("t2_af_at11", 32'(af_at11), 0);
        check("t2_af_at12", 32'(af_at12), 1);
        check("t2_no_proto", 32'(bus.proto_err), 0);
        mon_on = 1'b0;

        // 6: source withdraws a stalled word.
        @(negedge wr_clk);
        bus.s_valid = 1'b0;
        @(negedge wr_clk);
        check("t6_proto_set", 32'(bus.proto_err), 1);
        repeat (3) @(negedge wr_clk);
        check("t6_proto_held", 32'(bus.proto_err), 1);

        // 5: reset while TWO and full; buffered words must vanish.
        #2;
        use_auto = 1'b0; full_force = 1'b1; wr_rst = 1'b1;
        #1;
        check("t5_wr_inc",   32'(bus.wr_inc), 0);
        check("t5_wr_data",  32'(bus.wr_data), 0);
        check("t5_s_ready",  32'(bus.s_ready), 0);
        check("t5_count",    32'(bus.wr_count), 0);
        check("t5_afull",    32'(bus.wr_almost_full), 0);
        check("t5_proto",    32'(bus.proto_err), 0);
        @(negedge wr_clk);
        wr_rst = 1'b0;
        #1 check("t5_ready_pre", 32'(bus.s_ready), 0);
        @(posedge wr_clk); #1 check("t5_ready_rise", 32'(bus.s_ready), 1);
        @(negedge wr_clk); full_force = 1'b0;
        repeat (2) @(negedge wr_clk);
        check("t5_no_ghost", 32'(wr_log.size()), 16);
        full_force = 1'b1;
        send_words(8'hA5, 1, 4, 1'b1, sent, fc, gaps);
        check("t5_sent", 32'(sent), 1);
        repeat (3) @(negedge wr_clk);
        check("t5_full_hold_inc", 32'(bus.wr_inc), 0);
        check("t5_full_hold_log", 32'(wr_log.size()), 16);
        full_force = 1'b0;
        #1;
        check("t5_release_inc", 32'(bus.wr_inc), 1);
        check("t5_release_data", 32'(bus.wr_data), 32'h0A5);
        @(negedge wr_clk);
        check("t5_written", 32'(wr_log.size()), 17);
        check("t5_last", 32'(wr_log[$]), 32'h0A5);

        // 7: toggling backpressure exercises ONE<->TWO; order must survive.
        do_reset();
        toggle_on = 1'b1;
        send_words(8'hC0, 12, 60, 1'b1, sent, fc, gaps);
        check("t7_sent", 32'(sent), 12);
        for (int i = 0; i < 40 && wr_log.size() < 12; i++) @(negedge wr_clk);
        toggle_on = 1'b0;
        check_log("t7", 8'hC0, 12);
        check("t7_no_proto", 32'(bus.proto_err), 0);

        // 3: pointer wrap, 35 written, 30 read.
        do_reset();
        use_auto  = 1'b1;
        reader_on = 1'b1;
        send_words(8'h80, 35, 200, 1'b1, sent, fc, gaps);
        check("t3_sent", 32'(sent), 35);
        for (int i = 0; i < 100 && (wr_log.size() < 35 || rd_cnt < 30); i++) @(negedge wr_clk);
        repeat (4) @(negedge wr_clk);
        check("t3_count", 32'(bus.wr_count), 5);
        check("t3_afull", 32'(bus.wr_almost_full), 0);
        check_log("t3", 8'h80, 35);
        reader_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
